// File: rtl/register_tree_queue.sv
// Binary-tree register priority queue (max or min); push/pop/replace, then 2*TREE_DEPTH settle cycles.
// Backpressure: i_ready and o_valid are low while settling; i_ready is also low when the queue is full.
module register_tree_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int TREE_DEPTH = 3,
  parameter bit MAX_MODE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [$clog2(2**TREE_DEPTH)-1:0] o_size,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int N          = 2**TREE_DEPTH - 1;
  localparam int SW         = $clog2(N + 1);
  localparam int SETTLE_CYC = 2 * TREE_DEPTH;
  localparam int CW         = $clog2(SETTLE_CYC + 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t                state;
  logic                  ph;
  logic [CW-1:0]         cnt;
  logic                  nv [N];
  logic [DATA_WIDTH-1:0] nk [N];
  logic                  sw_v [N];
  logic [DATA_WIDTH-1:0] sw_k [N];
  logic [SW-1:0]         last;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  take_left;
  logic                  cv;
  logic [DATA_WIDTH-1:0] ck;

  function automatic int lvl(input int k);
    return $clog2(k + 2) - 1;
  endfunction

  // Strict ordering; an invalid node ranks below every valid key.
  function automatic logic beats(input logic av, input logic [DATA_WIDTH-1:0] ak,
                                 input logic bv, input logic [DATA_WIDTH-1:0] bk);
    if (!av) return 1'b0;
    if (!bv) return 1'b1;
    return MAX_MODE ? (ak > bk) : (ak < bk);
  endfunction

  assign o_full    = (o_size == SW'(N));
  assign o_empty   = (o_size == '0);
  assign o_valid   = (state == IDLE) && !o_empty;
  assign i_ready   = (state == IDLE) && !o_full;
  assign o_data    = nv[0] ? nk[0] : '0;
  assign last      = o_size - SW'(1);
  assign pop_fire  = o_valid && o_ready;
  assign push_fire = i_valid && (state == IDLE) && (!o_full || pop_fire);

  // Parents of one level parity swap together; their node sets never overlap.
  always_comb begin
    take_left = 1'b0;
    cv        = 1'b0;
    ck        = '0;
    for (int k = 0; k < N; k++) begin
      sw_v[k] = nv[k];
      sw_k[k] = nk[k];
    end
    for (int p = 0; p < N / 2; p++) begin
      if (((lvl(p) % 2) == 1) == ph) begin
        take_left = beats(nv[2*p+1], nk[2*p+1], nv[2*p+2], nk[2*p+2]);
        cv        = take_left ? nv[2*p+1] : nv[2*p+2];
        ck        = take_left ? nk[2*p+1] : nk[2*p+2];
        if (beats(cv, ck, nv[p], nk[p])) begin
          sw_v[p] = cv;
          sw_k[p] = ck;
          if (take_left) begin
            sw_v[2*p+1] = nv[p];
            sw_k[2*p+1] = nk[p];
          end else begin
            sw_v[2*p+2] = nv[p];
            sw_k[2*p+2] = nk[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ph     <= 1'b0;
      cnt    <= '0;
      o_size <= '0;
      for (int k = 0; k < N; k++) begin
        nv[k] <= 1'b0;
        nk[k] <= '0;
      end
    end else begin
      ph <= ~ph;
      case (state)
        IDLE: begin
          if (push_fire || pop_fire) begin
            state <= SETTLE;
            cnt   <= CW'(SETTLE_CYC);
          end
          if (push_fire && pop_fire) begin
            nv[0] <= 1'b1;
            nk[0] <= i_data;
          end else if (push_fire) begin
            nv[o_size] <= 1'b1;
            nk[o_size] <= i_data;
            o_size     <= o_size + SW'(1);
          end else if (pop_fire) begin
            // With one entry last==0, so the invalidation below wins.
            nv[0]    <= nv[last];
            nk[0]    <= nk[last];
            nv[last] <= 1'b0;
            nk[last] <= '0;
            o_size   <= last;
          end
        end
        SETTLE: begin
          for (int k = 0; k < N; k++) begin
            nv[k] <= sw_v[k];
            nk[k] <= sw_k[k];
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_tree_queue.sv
// Scoreboard bench for register_tree_queue: a max instance (index 0) and a min instance (index 1).
module tb_register_tree_queue;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][7:0] in_dat;
  logic [1:0]      in_vld;
  logic [1:0]      in_rdy;
  logic [1:0][7:0] out_dat;
  logic [1:0]      out_vld;
  logic [1:0]      out_rdy;
  logic [1:0][2:0] size;
  logic [1:0]      full;
  logic [1:0]      empty;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;

  register_tree_queue #(.DATA_WIDTH(8), .TREE_DEPTH(3), .MAX_MODE(1'b1)) dut_max (
    .clk(clk), .rst(rst), .i_data(in_dat[0]), .i_valid(in_vld[0]), .i_ready(in_rdy[0]),
    .o_data(out_dat[0]), .o_valid(out_vld[0]), .o_ready(out_rdy[0]),
    .o_size(size[0]), .o_full(full[0]), .o_empty(empty[0]));

  register_tree_queue #(.DATA_WIDTH(8), .TREE_DEPTH(3), .MAX_MODE(1'b0)) dut_min (
    .clk(clk), .rst(rst), .i_data(in_dat[1]), .i_valid(in_vld[1]), .i_ready(in_rdy[1]),
    .o_data(out_dat[1]), .o_valid(out_vld[1]), .o_ready(out_rdy[1]),
    .o_size(size[1]), .o_full(full[1]), .o_empty(empty[1]));

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every pop handshake is checked against the oldest expected key.
  always @(negedge clk) begin
    logic [7:0] e;
    if (out_vld[0] && out_rdy[0]) begin
      if (exp_q0.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_max: unexpected pop of %0d", out_dat[0]);
      end else begin
        e = exp_q0.pop_front();
        check("pop_max", int'(out_dat[0]), int'(e));
      end
    end
    if (out_vld[1] && out_rdy[1]) begin
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_min: unexpected pop of %0d", out_dat[1]);
      end else begin
        e = exp_q1.pop_front();
        check("pop_min", int'(out_dat[1]), int'(e));
      end
    end
  end

  task automatic wait_idle(input int s);
    int n = 0;
    while (!(in_rdy[s] || out_vld[s])) begin
      if (n == 40) begin
        total++; bad++;
        $display("FAIL idle_timeout: dut %0d still settling after %0d cycles", s, n);
        return;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic push(input int s, input logic [7:0] v);
    wait_idle(s);
    in_dat[s] = v;
    in_vld[s] = 1'b1;
    @(posedge clk); #1;
    in_vld[s] = 1'b0;
  endtask

  task automatic pop(input int s, input logic [7:0] expv);
    wait_idle(s);
    if (s == 0) exp_q0.push_back(expv);
    else        exp_q1.push_back(expv);
    out_rdy[s] = 1'b1;
    @(posedge clk); #1;
    out_rdy[s] = 1'b0;
  endtask

  task automatic fill_max();
    logic [7:0] vals [7] = '{8'd5, 8'd9, 8'd1, 8'd7, 8'd3, 8'd8, 8'd2};
    for (int i = 0; i < 7; i++) begin
      push(0, vals[i]);
      check("size_after_push", int'(size[0]), i + 1);
    end
    wait_idle(0);
  endtask

  initial begin
    logic [7:0] drain1 [7] = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1};
    logic [7:0] drain2 [7] = '{8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    logic [7:0] minv   [4] = '{8'd6, 8'd6, 8'd2, 8'd9};
    logic [7:0] mino   [4] = '{8'd2, 8'd6, 8'd6, 8'd9};

    rst = 1'b1; in_dat = '0; in_vld = '0; out_rdy = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_empty",  int'(empty[0]),   1);
    check("rst_iready", int'(in_rdy[0]),  1);
    check("rst_ovalid", int'(out_vld[0]), 0);
    check("rst_odata",  int'(out_dat[0]), 0);
    check("rst_full",   int'(full[0]),    0);
    check("rst_size",   int'(size[0]),    0);

    fill_max();
    check("full_top",    int'(out_dat[0]), 9);
    check("full_size",   int'(size[0]),    7);
    check("full_flag",   int'(full[0]),    1);
    check("full_iready", int'(in_rdy[0]),  0);
    check("full_ovalid", int'(out_vld[0]), 1);

    for (int i = 0; i < 7; i++) pop(0, drain1[i]);
    wait_idle(0);
    check("drain_empty",  int'(empty[0]),   1);
    check("drain_ovalid", int'(out_vld[0]), 0);
    check("drain_odata",  int'(out_dat[0]), 0);

    // Replace on a full queue: 9 leaves, 4 enters, size unchanged.
    fill_max();
    exp_q0.push_back(8'd9);
    in_dat[0] = 8'd4; in_vld[0] = 1'b1; out_rdy[0] = 1'b1;
    @(posedge clk); #1;
    in_vld[0] = 1'b0; out_rdy[0] = 1'b0;
    check("repl_size",   int'(size[0]),    7);
    check("repl_busy",   int'({in_rdy[0], out_vld[0]}), 0);
    wait_idle(0);
    check("repl_top",    int'(out_dat[0]), 8);
    check("repl_full",   int'(full[0]),    1);
    for (int i = 0; i < 7; i++) pop(0, drain2[i]);

    for (int i = 0; i < 4; i++) push(1, minv[i]);
    wait_idle(1);
    check("min_top", int'(out_dat[1]), 2);
    for (int i = 0; i < 4; i++) pop(1, mino[i]);
    wait_idle(1);
    check("min_empty", int'(empty[1]), 1);

    // Gating: accepts only every 7th cycle while both sides are held requesting.
    wait_idle(0);
    push(0, 8'd5);
    exp_q0.push_back(8'd5);
    exp_q0.push_back(8'd37);
    in_vld[0] = 1'b1; out_rdy[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      in_dat[0] = 8'(30 + k);
      check($sformatf("gate_k%0d", k), int'({in_rdy[0], out_vld[0]}), (k % 7 == 0) ? 3 : 0);
      check($sformatf("gate_size_k%0d", k), int'(size[0]), 1);
      @(posedge clk); #1;
    end
    in_vld[0] = 1'b0; out_rdy[0] = 1'b0;
    check("gate_top", int'(out_dat[0]), 44);
    pop(0, 8'd44);

    // Reset on the second settle cycle of the third push.
    wait_idle(0);
    push(0, 8'd10);
    push(0, 8'd20);
    push(0, 8'd30);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_size",   int'(size[0]),    0);
    check("mrst_odata",  int'(out_dat[0]), 0);
    check("mrst_ovalid", int'(out_vld[0]), 0);
    check("mrst_iready", int'(in_rdy[0]),  1);

    repeat (2) @(posedge clk);
    #1;
    check("left_exp_max", exp_q0.size(), 0);
    check("left_exp_min", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
